fp_sqrt_rnd: RTL and testbench

Iterative IEEE-754 binary32 square-root unit with integrated rounding. It accepts one operand on a start pulse and computes the root with a radix-2 digit recurrence, one result bit per cycle. It rounds the result per the requested mode and returns the result with the RISC-V-style exception flags. It sits in the FPU beside the divider as a multi-cycle functional unit.

---
 rtl/fp_sqrt_rnd.sv | 193 +++++++++++++++++++
 tb/tb_fp_sqrt_rnd.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_sqrt_rnd.sv
// Iterative binary32 square root: one restoring radix-2 root bit per cycle, then rounding.
// Special operands are decoded at accept time but still take the full fixed latency.
module fp_sqrt_rnd #(
  parameter int unsigned FP_FORMAT = 0
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] a_i,
  input  logic        start_i,
  input  logic [2:0]  rnd_i,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  flags_o
);

  // Only binary32 is implemented; every FP_FORMAT value selects it.
  localparam int Bias = (FP_FORMAT == 0) ? 127 : 127;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StCalc = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [4:0] LastIter = 5'd25;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [49:0] rad_q, rad_d;
  logic [26:0] rem_q, rem_d;
  logic [24:0] root_q, root_d;
  logic [7:0]  exp_q, exp_d;
  logic [2:0]  rnd_q, rnd_d;
  logic        special_q, special_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic        spec_nv_q, spec_nv_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  flags_q, flags_d;

  // Operand decode, used only on the accepting edge
  logic        in_sign, is_nan, is_inf, is_zero, in_special, in_nv, odd_exp;
  logic [7:0]  in_exp, exp_eff, acc_exp;
  logic [22:0] in_frac;
  logic [23:0] mant, norm;
  logic [4:0]  lz;
  logic [24:0] sig;
  logic signed [9:0] e_unb, e_even;
  logic [31:0] in_res;

  always_comb begin
    in_sign = a_i[31];
    in_exp  = a_i[30:23];
    in_frac = a_i[22:0];
    is_nan  = (in_exp == 8'hFF) && (in_frac != 23'd0);
    is_inf  = (in_exp == 8'hFF) && (in_frac == 23'd0);
    is_zero = (in_exp == 8'h00) && (in_frac == 23'd0);

    mant = {(in_exp != 8'h00), in_frac};
    lz   = 5'd0;
    for (int i = 0; i < 24; i++) begin
      if (mant[i]) lz = 5'(23 - i);
    end
    norm    = mant << lz;
    exp_eff = (in_exp == 8'h00) ? 8'd1 : in_exp;
    e_unb   = $signed({2'b00, exp_eff}) - $signed(10'(Bias)) - $signed({5'b00000, lz});
    odd_exp = e_unb[0];
    // An odd exponent is made even by doubling the significand into [2,4)
    sig     = odd_exp ? {norm, 1'b0} : {1'b0, norm};
    e_even  = odd_exp ? (e_unb - 10'sd1) : e_unb;
    acc_exp = 8'((e_even >>> 1) + $signed(10'(Bias)));

    in_special = is_nan || is_inf || is_zero || in_sign;
    in_nv      = 1'b0;
    in_res     = 32'h7FC0_0000;
    if (is_nan) begin
      in_nv = ~in_frac[22];
    end else if (in_sign && !is_zero) begin
      in_nv = 1'b1;
    end else if (is_zero) begin
      in_res = a_i;
    end else if (is_inf) begin
      in_res = 32'h7F80_0000;
    end
  end

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1
  logic [28:0] rem_sh, trial;
  logic        take;
  logic [26:0] rem_it;

  always_comb begin
    rem_sh = {rem_q, rad_q[49:48]};
    trial  = {2'b00, root_q, 2'b01};
    take   = (rem_sh >= trial);
    rem_it = take ? 27'(rem_sh - trial) : 27'(rem_sh);
  end

  logic        rbit, lsb, sticky, inc;
  logic [31:0] rounded;

  always_comb begin
    rbit   = root_q[0];
    lsb    = root_q[1];
    sticky = |rem_q;
    unique case (rnd_q)
      3'd1, 3'd2: inc = 1'b0;
      3'd3:       inc = rbit | sticky;
      3'd4:       inc = rbit;
      default:    inc = rbit & (sticky | lsb);
    endcase
    // A mantissa carry-out ripples straight into the exponent field
    rounded = {1'b0, exp_q, root_q[23:1]} + {31'd0, inc};
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    exp_d      = exp_q;
    rnd_d      = rnd_q;
    special_d  = special_q;
    spec_res_d = spec_res_q;
    spec_nv_d  = spec_nv_q;
    result_d   = result_q;
    flags_d    = flags_q;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d    = StCalc;
          cnt_d      = 5'd0;
          rad_d      = {sig, 25'd0};
          rem_d      = 27'd0;
          root_d     = 25'd0;
          exp_d      = acc_exp;
          rnd_d      = rnd_i;
          special_d  = in_special;
          spec_res_d = in_res;
          spec_nv_d  = in_nv;
        end
      end
      StCalc: begin
        if (cnt_q == LastIter) begin
          state_d  = StDone;
          result_d = special_q ? spec_res_q : rounded;
          flags_d  = special_q ? {spec_nv_q, 4'b0000} : {4'b0000, rbit | sticky};
        end else begin
          rad_d  = {rad_q[47:0], 2'b00};
          rem_d  = rem_it;
          root_d = {root_q[23:0], take};
          cnt_d  = cnt_q + 5'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= StIdle;
      cnt_q      <= 5'd0;
      rad_q      <= 50'd0;
      rem_q      <= 27'd0;
      root_q     <= 25'd0;
      exp_q      <= 8'd0;
      rnd_q      <= 3'd0;
      special_q  <= 1'b0;
      spec_res_q <= 32'd0;
      spec_nv_q  <= 1'b0;
      result_q   <= 32'd0;
      flags_q    <= 5'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      exp_q      <= exp_d;
      rnd_q      <= rnd_d;
      special_q  <= special_d;
      spec_res_q <= spec_res_d;
      spec_nv_q  <= spec_nv_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

  assign done_o   = (state_q == StDone);
  assign result_o = result_q;
  assign flags_o  = flags_q;

endmodule

// File: tb/tb_fp_sqrt_rnd.sv
// Scoreboard bench for fp_sqrt_rnd: expected results are queued at start and
// compared on each done_o pulse; the reference root comes from a squaring search.
module tb_fp_sqrt_rnd;

  logic        clk;
  logic        reset_i;
  logic [31:0] a_i;
  logic        start_i;
  logic [2:0]  rnd_i;
  logic        done_o;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [36:0] sb[$];
  logic [31:0] opq[$];

  fp_sqrt_rnd #(.FP_FORMAT(0)) dut (
    .clk_i    (clk),
    .reset_i  (reset_i),
    .a_i      (a_i),
    .start_i  (start_i),
    .rnd_i    (rnd_i),
    .done_o   (done_o),
    .result_o (result_o),
    .flags_o  (flags_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [36:0] model(input logic [31:0] a, input logic [2:0] rm);
    logic [7:0]  ex;
    logic [22:0] fr;
    longint unsigned m, n, r, t;
    int e;
    logic rb, lb, st, inc;
    logic [31:0] res;
    ex = a[30:23];
    fr = a[22:0];
    if (ex == 8'hFF && fr != 23'd0) return {~fr[22], 4'b0000, 32'h7FC00000};
    if (ex == 8'h00 && fr == 23'd0) return {5'b00000, a};
    if (a[31]) return {5'b10000, 32'h7FC00000};
    if (ex == 8'hFF) return {5'b00000, 32'h7F800000};
    if (ex == 8'h00) begin
      m = 64'(fr);
      e = -126;
    end else begin
      m = 64'({1'b1, fr});
      e = int'(ex) - 127;
    end
    while (m < 64'h800000) begin
      m = m << 1;
      e = e - 1;
    end
    if (e % 2 != 0) begin
      m = m << 1;
      e = e - 1;
    end
    n = m << 25;
    r = 0;
    for (int b = 24; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= n) r = t;
    end
    rb = r[0];
    lb = r[1];
    st = (r * r != n);
    case (rm)
      3'd1, 3'd2: inc = 1'b0;
      3'd3:       inc = rb | st;
      3'd4:       inc = rb;
      default:    inc = rb & (st | lb);
    endcase
    res = {1'b0, 8'(e / 2 + 127), r[23:1]} + {31'd0, inc};
    return {4'b0000, rb | st, res};
  endfunction

  // Scoreboard: every done_o pulse retires the oldest queued expectation
  always @(negedge clk) begin
    logic [36:0] ev;
    logic [31:0] op;
    if (done_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done at %0t: done_o=1 required 0", $time);
      end else begin
        ev = sb.pop_front();
        op = opq.pop_front();
        n_cmp++;
        if (result_o !== ev[31:0]) begin
          n_fail++;
          $display("FAIL result a=%h: got %h required %h", op, result_o, ev[31:0]);
        end
        n_cmp++;
        if (flags_o !== ev[36:32]) begin
          n_fail++;
          $display("FAIL flags a=%h: got %b required %b", op, flags_o, ev[36:32]);
        end
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [2:0] rm);
    sb.push_back(model(a, rm));
    opq.push_back(a);
  endtask

  // Issues one operation, scrambles the inputs after acceptance, waits for done_o.
  task automatic run_op(input logic [31:0] a, input logic [2:0] rm);
    int k;
    @(negedge clk);
    a_i = a;
    rnd_i = rm;
    start_i = 1'b1;
    push_exp(a, rm);
    @(negedge clk);
    start_i = 1'b0;
    a_i = $urandom;
    rnd_i = 3'($urandom_range(0, 7));
    k = 0;
    while (!done_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout a=%h: done_o=0 after %0d cycles, required 1", a, k);
      if (sb.size() != 0) begin
        void'(sb.pop_front());
        void'(opq.pop_front());
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    start_i = 1'b0;
    a_i = 32'd0;
    rnd_i = 3'd0;
    #2 reset_i = 1'b0;
    #2;
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_done: got %b required 0", done_o);
    end
    n_cmp++;
    if (result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_result: got %h required 00000000", result_o);
    end
    n_cmp++;
    if (flags_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 00000", flags_o);
    end
    repeat (3) @(negedge clk);
    reset_i = 1'b1;
  endtask

  task automatic test_latency();
    int first;
    int pulses;
    @(negedge clk);
    a_i = 32'h40800000;
    rnd_i = 3'd0;
    start_i = 1'b1;
    push_exp(32'h40800000, 3'd0);
    @(posedge clk);
    #1 start_i = 1'b0;
    first = 0;
    pulses = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    n_cmp++;
    if (first != 26) begin
      n_fail++;
      $display("FAIL latency: done_o first after edge %0d, required 26", first);
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL done_pulses: got %0d required 1", pulses);
    end
  endtask

  task automatic test_round_modes();
    for (int m = 0; m < 5; m++) run_op(32'h40000000, 3'(m));
    run_op(32'h40400000, 3'd3);
    run_op(32'h3F800000, 3'd0);
  endtask

  task automatic test_specials();
    logic [31:0] sp[7];
    sp = '{32'hBF800000, 32'h7F800001, 32'h7FC00001, 32'h80000000,
           32'h7F800000, 32'h00000000, 32'hFF800000};
    foreach (sp[i]) run_op(sp[i], 3'(i % 5));
  endtask

  task automatic test_subnormal();
    run_op(32'h00000001, 3'd0);
    run_op(32'h007FFFFF, 3'd3);
    run_op(32'h00000003, 3'd4);
    run_op(32'h7F7FFFFF, 3'd3);
  endtask

  task automatic test_back_to_back();
    int k;
    int extra;
    @(negedge clk);
    a_i = 32'h40800000;
    rnd_i = 3'd0;
    start_i = 1'b1;
    push_exp(32'h40800000, 3'd0);
    @(negedge clk);
    // start_i stays high; the second operand is what the auto-restart must capture
    a_i = 32'h40000000;
    rnd_i = 3'd3;
    push_exp(32'h40000000, 3'd3);
    k = 0;
    while (!done_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    repeat (2) @(negedge clk);
    start_i = 1'b0;
    a_i = 32'h3F800000;
    rnd_i = 3'd1;
    k = 0;
    while (!done_o && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (!done_o) begin
      n_fail++;
      $display("FAIL b2b_second_done: done_o=0 after %0d cycles, required 1", k);
    end
    extra = 0;
    repeat (35) begin
      @(negedge clk);
      if (done_o) extra++;
    end
    n_cmp++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_extra_done: got %0d pulses required 0", extra);
    end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk);
    a_i = 32'h40000000;
    rnd_i = 3'd0;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
    n_cmp++;
    if (result_o !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_result: got %h required 00000000", result_o);
    end
    n_cmp++;
    if (flags_o !== 5'd0) begin
      n_fail++;
      $display("FAIL abort_flags: got %b required 00000", flags_o);
    end
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_done: got %b required 0", done_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d pulses required 0", pulses);
    end
    run_op(32'h3F800000, 3'd0);
  endtask

  task automatic test_bulk();
    logic [7:0]  ex;
    logic [22:0] fr;
    for (int i = 0; i < 40; i++) begin
      fr = 23'($urandom);
      if (i % 3 == 0) begin
        ex = 8'h00;
        fr = fr | 23'd1;
      end else begin
        ex = 8'($urandom_range(1, 254));
      end
      run_op({1'b0, ex, fr}, 3'(i % 8));
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_modes();
    test_specials();
    test_subnormal();
    test_back_to_back();
    test_abort();
    test_bulk();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL pending_results: got %0d outstanding required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
